// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 key schedule definitions used by key_expand and its bench.
//   state_t       : key_expand FSM state encoding (IDLE, EMIT, DONE)
//   AES128_ROUNDS : round keys produced after round key 0 for AES-128
//   RCON_POLY     : GF(2^8) reduction constant applied when Rcon overflows
//   key_t         : 128-bit key, bit 0 = MSB of byte 0
// ----------------------------------------------------------------------------
package aes_pkg;

   typedef enum logic [1:0] {
      IDLE,
      EMIT,
      DONE
   } state_t;

   localparam int AES128_ROUNDS = 10;

   localparam logic [7:0] RCON_POLY = 8'h1b;

   typedef logic [0:127] key_t;

endpackage

// File: rtl/key_expand_sub_word.sv
// ----------------------------------------------------------------------------
// sub_word
// Purely combinational AES SubWord: four parallel S-box lookups, one per byte.
// Ports:
//   word_in  [0:31] : input word, bits 0..7 = byte 0
//   word_out [0:31] : S-box substituted word, same byte order
// ----------------------------------------------------------------------------
module sub_word (
   input  logic [0:31] word_in,
   output logic [0:31] word_out
);

   // Forward AES S-box, indexed by the input byte value.
   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Each byte is substituted independently, so the four lookups run in parallel.
   assign word_out[0:7]   = SBOX[word_in[0:7]];
   assign word_out[8:15]  = SBOX[word_in[8:15]];
   assign word_out[16:23] = SBOX[word_in[16:23]];
   assign word_out[24:31] = SBOX[word_in[24:31]];

endmodule

// File: rtl/key_expand.sv
// ----------------------------------------------------------------------------
// key_expand
// Streams the AES-128 round keys 0..ROUNDS for a cipher key, one key per cycle
// under a valid/ready handshake.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   start              : one-cycle request to expand key_in (honoured in IDLE only)
//   key_in   [0:127]   : cipher key, bit 0 = MSB of byte 0
//   rk_ready           : consumer accepts the current round key
//   rk_valid           : round_key / rk_idx are valid
//   round_key [0:127]  : current round key
//   rk_idx   [0:3]     : round number of round_key
//   busy               : expansion in progress (EMIT or DONE)
//   done               : one-cycle pulse after the last round key is accepted
// Optional feature (macro KEY_EXPAND_STORE_EN):
//   rd_addr  [0:3]     : read address into the stored round keys
//   rd_key   [0:127]   : stored round key, zero for addresses beyond ROUNDS
// ----------------------------------------------------------------------------
module key_expand
   import aes_pkg::*;
#(
   parameter int ROUNDS = AES128_ROUNDS
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  key_t         key_in,
   input  logic         rk_ready,
   output logic         rk_valid,
   output key_t         round_key,
   output logic [0:3]   rk_idx,
   output logic         busy,
   output logic         done
`ifdef KEY_EXPAND_STORE_EN
   ,
   input  logic [0:3]   rd_addr,
   output key_t         rd_key
`endif
);

   localparam logic [0:3] LAST_IDX = 4'(ROUNDS);

   state_t      state;
   logic [7:0]  rcon;
   logic        accept;
   logic        last_key;
   logic [0:31] w0, w1, w2, w3;
   logic [0:31] rot_w3, sub_rot_w3;
   logic [0:31] w4, w5, w6, w7;

   // Multiply by x in GF(2^8); Rcon for the next round.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
   endfunction

   assign accept   = rk_valid && rk_ready;
   assign last_key = (rk_idx == LAST_IDX);

   assign w0 = round_key[0:31];
   assign w1 = round_key[32:63];
   assign w2 = round_key[64:95];
   assign w3 = round_key[96:127];

   // RotWord moves byte 0 to the end of the word.
   assign rot_w3 = {w3[8:31], w3[0:7]};

   sub_word u_sub_word (
      .word_in  (rot_w3),
      .word_out (sub_rot_w3)
   );

   // The next round key is a ripple of XORs seeded by the transformed last word.
   assign w4 = w0 ^ sub_rot_w3 ^ {rcon, 24'h000000};
   assign w5 = w4 ^ w1;
   assign w6 = w5 ^ w2;
   assign w7 = w6 ^ w3;

   // Control FSM. All outputs are registered; round_key only moves on an
   // accepted handshake, so it is stable while the consumer stalls. start is
   // only looked at in IDLE, which makes it inert during EMIT and DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rk_valid  <= 1'b0;
         round_key <= '0;
         rk_idx    <= '0;
         rcon      <= 8'h01;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  round_key <= key_in;
                  rk_idx    <= '0;
                  rcon      <= 8'h01;
                  rk_valid  <= 1'b1;
                  busy      <= 1'b1;
                  state     <= EMIT;
               end
            end
            EMIT: begin
               if (accept) begin
                  if (last_key) begin
                     rk_valid <= 1'b0;
                     done     <= 1'b1;
                     state    <= DONE;
                  end else begin
                     round_key <= {w4, w5, w6, w7};
                     rk_idx    <= rk_idx + 4'd1;
                     rcon      <= xtime(rcon);
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               rk_valid <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

`ifdef KEY_EXPAND_STORE_EN
   key_t key_file [0:ROUNDS];

   // Every accepted round key is recorded at its round number; entries from a
   // previous expansion survive until the next expansion overwrites them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= ROUNDS; i++) begin
            key_file[i] <= '0;
         end
      end else if (accept) begin
         key_file[rk_idx] <= round_key;
      end
   end

   // Addresses past the last round have no entry and read back as zero.
   always_comb begin
      rd_key = '0;
      if (rd_addr <= LAST_IDX) begin
         rd_key = key_file[rd_addr];
      end
   end
`endif

endmodule

// File: tb/tb_key_expand.sv
// ----------------------------------------------------------------------------
// tb_key_expand
// Directed self-checking bench for key_expand using the FIPS-197 AES-128
// example key and the all-zero key. Define KEY_EXPAND_STORE_EN to also cover
// the stored round key read port.
// ----------------------------------------------------------------------------
module tb_key_expand;
   import aes_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   key_t       key_in;
   logic       rk_ready;
   logic       rk_valid;
   key_t       round_key;
   logic [0:3] rk_idx;
   logic       busy;
   logic       done;
`ifdef KEY_EXPAND_STORE_EN
   logic [0:3] rd_addr;
   key_t       rd_key;
`endif

   int n_compared   = 0;
   int n_mismatched = 0;

   localparam key_t FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam key_t ZERO_RK1 = 128'h62636363626363636263636362636363;

   // FIPS-197 Appendix A.1 round keys 0..10 for FIPS_KEY.
   key_t fips_rk [0:10] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
   };

   key_expand dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .key_in    (key_in),
      .rk_ready  (rk_ready),
      .rk_valid  (rk_valid),
      .round_key (round_key),
      .rk_idx    (rk_idx),
      .busy      (busy),
      .done      (done)
`ifdef KEY_EXPAND_STORE_EN
      ,
      .rd_addr   (rd_addr),
      .rd_key    (rd_key)
`endif
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic step_cycle();
      @(posedge clk);
      #1;
   endtask

   // Reset values, reset release with start on the first edge, stall at key 0,
   // then drain with rk_ready held high.
   task automatic test_reset();
      rst_n    = 1'b0;
      start    = 1'b0;
      rk_ready = 1'b0;
      key_in   = FIPS_KEY;
      #2;
      n_compared++; if (rk_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_valid got %b want 0", rk_valid); end
      n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_busy got %b want 0", busy); end
      n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_done got %b want 0", done); end
      n_compared++; if (rk_idx !== 4'd0) begin n_mismatched++; $display("[TB] FAIL rst_idx got %0d want 0", rk_idx); end
      n_compared++; if (round_key !== 128'h0) begin n_mismatched++; $display("[TB] FAIL rst_key got %h want 0", round_key); end
      step_cycle();
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b1;
      step_cycle();
      start = 1'b0;
      n_compared++; if (rk_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL first_start_valid got %b want 1", rk_valid); end
      n_compared++; if (round_key !== FIPS_KEY) begin n_mismatched++; $display("[TB] FAIL first_start_key got %h want %h", round_key, FIPS_KEY); end
      n_compared++; if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL first_start_busy got %b want 1", busy); end
      step_cycle();
      step_cycle();
      n_compared++; if (rk_idx !== 4'd0) begin n_mismatched++; $display("[TB] FAIL stall0_idx got %0d want 0", rk_idx); end
      n_compared++; if (round_key !== FIPS_KEY) begin n_mismatched++; $display("[TB] FAIL stall0_key got %h want %h", round_key, FIPS_KEY); end
      rk_ready = 1'b1;
      for (int i = 0; i < 11; i++) step_cycle();
      n_compared++; if (done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL drain_done got %b want 1", done); end
      step_cycle();
   endtask

   // rk_ready while nothing is valid must not move the index or raise valid.
   task automatic test_idle_ready();
      rk_ready = 1'b1;
      for (int i = 0; i < 3; i++) step_cycle();
      n_compared++; if (rk_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL idle_valid got %b want 0", rk_valid); end
      n_compared++; if (rk_idx !== 4'd10) begin n_mismatched++; $display("[TB] FAIL idle_idx got %0d want 10", rk_idx); end
      n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL idle_busy got %b want 0", busy); end
   endtask

   // Full FIPS-197 expansion at one key per cycle; done lands 12 edges after start.
   task automatic test_stream();
      key_in   = FIPS_KEY;
      rk_ready = 1'b1;
      start    = 1'b1;
      step_cycle();
      start = 1'b0;
      for (int i = 0; i <= 10; i++) begin
         n_compared++; if (rk_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL stream_valid[%0d] got %b want 1", i, rk_valid); end
         n_compared++; if (rk_idx !== 4'(i)) begin n_mismatched++; $display("[TB] FAIL stream_idx got %0d want %0d", rk_idx, i); end
         n_compared++; if (round_key !== fips_rk[i]) begin n_mismatched++; $display("[TB] FAIL stream_key[%0d] got %h want %h", i, round_key, fips_rk[i]); end
         step_cycle();
      end
      n_compared++; if (done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL stream_done got %b want 1", done); end
      n_compared++; if (rk_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL stream_valid_end got %b want 0", rk_valid); end
      n_compared++; if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL stream_busy_done got %b want 1", busy); end
      step_cycle();
      n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL stream_done_pulse got %b want 0", done); end
      n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL stream_busy_idle got %b want 0", busy); end
   endtask

`ifdef KEY_EXPAND_STORE_EN
   // Read back the keys stored by the previous full expansion.
   task automatic test_store();
      rd_addr = 4'd10;
      #1;
      n_compared++; if (rd_key !== fips_rk[10]) begin n_mismatched++; $display("[TB] FAIL store_rd10 got %h want %h", rd_key, fips_rk[10]); end
      rd_addr = 4'd11;
      #1;
      n_compared++; if (rd_key !== 128'h0) begin n_mismatched++; $display("[TB] FAIL store_rd11 got %h want 0", rd_key); end
      rd_addr = 4'd1;
      #1;
      n_compared++; if (rd_key !== fips_rk[1]) begin n_mismatched++; $display("[TB] FAIL store_rd1 got %h want %h", rd_key, fips_rk[1]); end
   endtask
`endif

   // Consumer stalls for five cycles at round 3, then resumes.
   task automatic test_backpressure();
      key_in   = FIPS_KEY;
      rk_ready = 1'b1;
      start    = 1'b1;
      step_cycle();
      start = 1'b0;
      for (int i = 0; i <= 10; i++) begin
         n_compared++; if (rk_idx !== 4'(i)) begin n_mismatched++; $display("[TB] FAIL bp_idx got %0d want %0d", rk_idx, i); end
         n_compared++; if (round_key !== fips_rk[i]) begin n_mismatched++; $display("[TB] FAIL bp_key[%0d] got %h want %h", i, round_key, fips_rk[i]); end
         if (i == 3) begin
            rk_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
               step_cycle();
               n_compared++; if (rk_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bp_hold_valid got %b want 1", rk_valid); end
               n_compared++; if (rk_idx !== 4'd3) begin n_mismatched++; $display("[TB] FAIL bp_hold_idx got %0d want 3", rk_idx); end
               n_compared++; if (round_key !== fips_rk[3]) begin n_mismatched++; $display("[TB] FAIL bp_hold_key got %h want %h", round_key, fips_rk[3]); end
            end
            rk_ready = 1'b1;
         end
         step_cycle();
      end
      n_compared++; if (done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bp_done got %b want 1", done); end
      step_cycle();
   endtask

   // start mid-expansion and on the final acceptance edge are both ignored.
   task automatic test_start_ignored();
      key_in   = FIPS_KEY;
      rk_ready = 1'b1;
      start    = 1'b1;
      step_cycle();
      start = 1'b0;
      for (int i = 0; i <= 10; i++) begin
         n_compared++; if (rk_idx !== 4'(i)) begin n_mismatched++; $display("[TB] FAIL ign_idx got %0d want %0d", rk_idx, i); end
         n_compared++; if (round_key !== fips_rk[i]) begin n_mismatched++; $display("[TB] FAIL ign_key[%0d] got %h want %h", i, round_key, fips_rk[i]); end
         if (i == 5 || i == 10) begin
            start  = 1'b1;
            key_in = '1;
         end
         step_cycle();
         start  = 1'b0;
         key_in = FIPS_KEY;
      end
      n_compared++; if (done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ign_done got %b want 1", done); end
      n_compared++; if (rk_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ign_valid_done got %b want 0", rk_valid); end
      step_cycle();
      step_cycle();
      n_compared++; if (rk_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ign_no_restart got %b want 0", rk_valid); end
      n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ign_busy got %b want 0", busy); end
   endtask

   // Asynchronous reset at round 6 between clock edges, then a zero-key run.
   task automatic test_async_reset();
      key_in   = FIPS_KEY;
      rk_ready = 1'b1;
      start    = 1'b1;
      step_cycle();
      start = 1'b0;
      for (int i = 0; i < 6; i++) step_cycle();
      n_compared++; if (round_key !== fips_rk[6]) begin n_mismatched++; $display("[TB] FAIL ar_pre_key got %h want %h", round_key, fips_rk[6]); end
      #2;
      rst_n = 1'b0;
      #1;
      n_compared++; if (rk_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ar_valid got %b want 0", rk_valid); end
      n_compared++; if (round_key !== 128'h0) begin n_mismatched++; $display("[TB] FAIL ar_key got %h want 0", round_key); end
      n_compared++; if (rk_idx !== 4'd0) begin n_mismatched++; $display("[TB] FAIL ar_idx got %0d want 0", rk_idx); end
      n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ar_busy got %b want 0", busy); end
`ifdef KEY_EXPAND_STORE_EN
      rd_addr = 4'd3;
      #1;
      n_compared++; if (rd_key !== 128'h0) begin n_mismatched++; $display("[TB] FAIL ar_store_clear got %h want 0", rd_key); end
`endif
      #1;
      rst_n  = 1'b1;
      key_in = '0;
      start  = 1'b1;
      step_cycle();
      start = 1'b0;
      n_compared++; if (round_key !== 128'h0) begin n_mismatched++; $display("[TB] FAIL zero_rk0 got %h want 0", round_key); end
      step_cycle();
      n_compared++; if (rk_idx !== 4'd1) begin n_mismatched++; $display("[TB] FAIL zero_idx1 got %0d want 1", rk_idx); end
      n_compared++; if (round_key !== ZERO_RK1) begin n_mismatched++; $display("[TB] FAIL zero_rk1 got %h want %h", round_key, ZERO_RK1); end
      for (int i = 1; i < 10; i++) step_cycle();
      n_compared++; if (rk_idx !== 4'd10) begin n_mismatched++; $display("[TB] FAIL zero_idx10 got %0d want 10", rk_idx); end
      step_cycle();
      n_compared++; if (done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL zero_done got %b want 1", done); end
      step_cycle();
   endtask

   initial begin
`ifdef KEY_EXPAND_STORE_EN
      rd_addr = 4'd0;
`endif
      test_reset();
      test_idle_ready();
      test_stream();
`ifdef KEY_EXPAND_STORE_EN
      test_store();
`endif
      test_backpressure();
      test_start_ignored();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/key_expand.md
KEY_EXPAND -- requirements
Module: key_expand

Interface
REQ-001 SHALL have parameter ROUNDS, default 10, number of round keys generated after round key 0 (AES-128).
REQ-002 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, one-cycle request to expand key_in.
REQ-005 SHALL have port key_in, input, [0:127], cipher key, bit 0 = MSB of byte 0.
REQ-006 SHALL have port rk_ready, input, 1, consumer accepts the current round key.
REQ-007 SHALL have port rk_valid, output, 1, round_key/rk_idx are valid.
REQ-008 SHALL have port round_key, output, [0:127], current round key, same bit order as key_in.
REQ-009 SHALL have port rk_idx, output, [0:3], round number of round_key, 0..ROUNDS.
REQ-010 SHALL have port busy, output, 1, expansion in progress.
REQ-011 SHALL have port done, output, 1, one-cycle pulse after round ROUNDS is accepted.

Function
REQ-012 SHALL use FSM states IDLE, EMIT, DONE.
REQ-013 IDLE: start=1 latches key_in and sets rk_idx=0 and Rcon=8'h01; next state EMIT, with rk_valid=1 in the following cycle.
REQ-014 EMIT: rk_valid=1; round_key is held stable until rk_valid&&rk_ready.
REQ-015 On acceptance with rk_idx<ROUNDS: next key w4=w0^SubWord(RotWord(w3))^{Rcon,24'h0}, w5=w4^w1, w6=w5^w2, w7=w6^w3; rk_idx increments; Rcon advances by GF(2^8) xtime (0x80 -> 0x1b); new key is valid the next cycle.
REQ-016 Throughput: one round key per cycle under continuous rk_ready=1; start-to-last-key latency is ROUNDS+1 cycles.
REQ-017 On acceptance with rk_idx==ROUNDS: go to DONE; rk_valid=0 the next cycle.
REQ-018 DONE: done=1 for exactly one cycle, then IDLE.
REQ-019 busy=1 in EMIT and DONE, 0 in IDLE.
REQ-020 start while busy=1 SHALL be ignored, with no effect on key, index or Rcon.
REQ-021 start and final acceptance in the same cycle: start is ignored, because the FSM is not in IDLE.
REQ-022 rk_ready while rk_valid=0 SHALL have no effect.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, rk_valid=0, busy=0, done=0, rk_idx=0, round_key=0, Rcon=8'h01, independent of clk.
REQ-024 Reset mid-expansion SHALL abort it; no partial-round key is presented after release.
REQ-025 First start after reset deassertion SHALL be honoured on the first rising clk edge.

Configuration
REQ-026 Macro KEY_EXPAND_STORE_EN SHALL, when defined, add input rd_addr [0:3] and output rd_key [0:127], plus an (ROUNDS+1)x128 register file written with each round key on acceptance.
REQ-027 With KEY_EXPAND_STORE_EN: rd_key=file[rd_addr] combinationally; rd_addr>ROUNDS returns 0; entries persist until overwritten by the next expansion; reset clears all entries.
REQ-028 Without KEY_EXPAND_STORE_EN: ports rd_addr/rd_key and the register file SHALL not exist; streaming behaviour is unchanged.

Structure
REQ-029 Shared package aes_pkg SHALL hold: FSM state enum, the AES-128 default ROUNDS constant, the Rcon reduction constant 8'h1b, and the 128-bit key type.
REQ-030 A single sub-module sub_word SHALL implement four parallel AES S-box lookups on a [0:31] word, combinationally.
REQ-031 RotWord, xor chain and Rcon stepping SHALL live in key_expand.

Verification
REQ-032 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> idx0 = key, idx1 a0fafe1788542cb123a339392a6c7605, idx10 d014f9a8c9ee2589e13f0cc8b6630ca6, done 12 cycles after start.
REQ-033 Same key, rk_ready held 0 for 5 cycles at idx3 -> round_key stays 3d80477d4716fe3e1e237e446d7a883b, rk_idx=3 throughout, then resumes.
REQ-034 start pulsed at idx5 -> sequence unchanged; idx10 value still d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-035 rst_n low at idx6 without a clk edge -> outputs zero immediately; a fresh start with key 0 gives idx1 62636363626363636263636362636363.
REQ-036 KEY_EXPAND_STORE_EN after REQ-032 -> rd_addr=10 reads d014f9a8c9ee2589e13f0cc8b6630ca6; rd_addr=11 reads 0.
